// File: rtl/hwloop_if.sv
// Setup, fetch-PC and redirect signals between decode/fetch and hwloop_ctrl.
// The cfg_level member exists only when HWLOOP_NEST_EN is defined.
interface hwloop_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [31:0]      cfg_start;
  logic [31:0]      cfg_end;
  logic [CNT_W-1:0] cfg_count;
`ifdef HWLOOP_NEST_EN
  logic             cfg_level;
`endif
  logic [31:0]      pc;
  logic             pc_valid;
  logic             abort;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             pc_hwl_end_zero_flag;
  logic             loop_active;
  logic [CNT_W-1:0] iter_remaining;
  logic             cfg_err;

  // Core side: issues setups and fetch PCs, consumes redirects.
  modport master (
`ifdef HWLOOP_NEST_EN
    output cfg_level,
`endif
    output cfg_valid, cfg_start, cfg_end, cfg_count, pc, pc_valid, abort,
    input  cfg_ready, redirect_valid, redirect_pc, pc_hwl_end_zero_flag,
           loop_active, iter_remaining, cfg_err
  );

  // Controller side.
  modport slave (
`ifdef HWLOOP_NEST_EN
    input  cfg_level,
`endif
    input  cfg_valid, cfg_start, cfg_end, cfg_count, pc, pc_valid, abort,
    output cfg_ready, redirect_valid, redirect_pc, pc_hwl_end_zero_flag,
           loop_active, iter_remaining, cfg_err
  );
endinterface

// File: rtl/hwloop_ctrl.sv
// Zero-overhead hardware-loop controller: combinational PC redirect at loop end,
// NOP substitution for zero-count loops. HWLOOP_NEST_EN adds a second (inner) level.
module hwloop_ctrl #(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  hwloop_if.slave bus
);

`ifdef HWLOOP_NEST_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SKIP = 2'd2
  } state_e;

  // Addresses are held as word addresses; the low two bits are implicitly zero.
  state_e           state_q [NL];
  state_e           state_d [NL];
  logic [29:0]      start_q [NL];
  logic [29:0]      start_d [NL];
  logic [29:0]      end_q   [NL];
  logic [29:0]      end_d   [NL];
  logic [CNT_W-1:0] cnt_q   [NL];
  logic [CNT_W-1:0] cnt_d   [NL];
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] iter_d;
  logic             cfg_err_q;
  logic             cfg_err_d;

  logic             act_s   [NL];
  logic             take_s  [NL];
  logic             go_s;
  logic             lvl_s;
  logic             lvl_idle_s;
  logic             flag_s;
  logic             active_s;
  logic             redirect_valid_s;
  logic [31:0]      redirect_pc_s;
  logic [29:0]      pc_w_s;
  logic             unused_s;

`ifdef HWLOOP_NEST_EN
  assign lvl_s = bus.cfg_level;
`else
  assign lvl_s = 1'b0;
`endif

  assign pc_w_s   = bus.pc[31:2];
  assign unused_s = ^{bus.pc[1:0], bus.cfg_start[1:0], bus.cfg_end[1:0]};

  // Level evaluation (inner first), redirect selection and next-state computation.
  always_comb begin
    state_d          = state_q;
    start_d          = start_q;
    end_d            = end_q;
    cnt_d            = cnt_q;
    cfg_err_d        = cfg_err_q;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'h0000_0000;
    flag_s           = 1'b0;
    active_s         = 1'b0;
    lvl_idle_s       = 1'b0;
    go_s             = bus.pc_valid & ~bus.abort;
    for (int l = NL - 1; l >= 0; l--) begin
      // An inner redirect hides the end-of-loop event from the outer level.
      act_s[l]         = go_s & (pc_w_s == end_q[l]);
      take_s[l]        = act_s[l] & (state_q[l] == S_RUN) & (cnt_q[l] > CNT_W'(1));
      redirect_valid_s = redirect_valid_s | take_s[l];
      redirect_pc_s    = take_s[l] ? {start_q[l], 2'b00} : redirect_pc_s;
      go_s             = go_s & ~take_s[l];

      flag_s     = flag_s | ((state_q[l] == S_SKIP) &&
                             (pc_w_s >= start_q[l]) && (pc_w_s <= end_q[l]));
      active_s   = active_s | (state_q[l] != S_IDLE);
      lvl_idle_s = lvl_idle_s | ((int'(lvl_s) == l) && (state_q[l] == S_IDLE));

      if (bus.abort) begin
        state_d[l] = S_IDLE;
        cnt_d[l]   = {CNT_W{1'b0}};
      end else begin
        case (state_q[l])
          S_IDLE: begin
            if (bus.cfg_valid && (int'(lvl_s) == l)) begin
              if (bus.cfg_end[31:2] < bus.cfg_start[31:2]) begin
                cfg_err_d = 1'b1;
              end else begin
                start_d[l] = bus.cfg_start[31:2];
                end_d[l]   = bus.cfg_end[31:2];
                cnt_d[l]   = bus.cfg_count;
                state_d[l] = (bus.cfg_count == {CNT_W{1'b0}}) ? S_SKIP : S_RUN;
              end
            end else begin
              state_d[l] = S_IDLE;
            end
          end
          S_RUN: begin
            if (take_s[l]) begin
              cnt_d[l] = cnt_q[l] - CNT_W'(1);
            end else if (act_s[l]) begin
              state_d[l] = S_IDLE;
              cnt_d[l]   = {CNT_W{1'b0}};
            end else begin
              state_d[l] = S_RUN;
            end
          end
          S_SKIP: begin
            if (act_s[l]) begin
              state_d[l] = S_IDLE;
            end else begin
              state_d[l] = S_SKIP;
            end
          end
          default: begin
            state_d[l] = S_IDLE;
            cnt_d[l]   = {CNT_W{1'b0}};
          end
        endcase
      end
    end

    iter_d = cnt_d[0];
    for (int l = 1; l < NL; l++) begin
      iter_d = (state_d[l] != S_IDLE) ? cnt_d[l] : iter_d;
    end
  end

  // State, address, counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        state_q[l] <= S_IDLE;
        start_q[l] <= 30'd0;
        end_q[l]   <= 30'd0;
        cnt_q[l]   <= {CNT_W{1'b0}};
      end
      iter_q    <= {CNT_W{1'b0}};
      cfg_err_q <= 1'b0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        state_q[l] <= state_d[l];
        start_q[l] <= start_d[l];
        end_q[l]   <= end_d[l];
        cnt_q[l]   <= cnt_d[l];
      end
      iter_q    <= iter_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.cfg_ready            = ~rst & ~bus.abort & lvl_idle_s;
  assign bus.redirect_valid       = redirect_valid_s;
  assign bus.redirect_pc          = redirect_pc_s;
  assign bus.pc_hwl_end_zero_flag = flag_s & ~bus.abort;
  assign bus.loop_active          = active_s;
  assign bus.iter_remaining       = iter_q;
  assign bus.cfg_err              = cfg_err_q;

endmodule

// File: tb/tb_hwloop_ctrl.sv
// Directed self-checking bench for hwloop_ctrl; the nested-loop sequence
// runs only when HWLOOP_NEST_EN is defined.
module tb_hwloop_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  hwloop_if #(.CNT_W(16)) bus ();

  hwloop_ctrl #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] e,
                       input logic [15:0] c, input logic [31:0] spc);
    bus.cfg_valid = 1'b1;
    bus.cfg_start = s;
    bus.cfg_end   = e;
    bus.cfg_count = c;
    bus.pc        = spc;
    bus.pc_valid  = 1'b1;
    #1;
    chk("cfg_ready_setup", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p, input logic exp_rv,
                       input logic [31:0] exp_pc, input string tag);
    bus.pc       = p;
    bus.pc_valid = 1'b1;
    #1;
    chk(tag, {31'd0, bus.redirect_valid}, {31'd0, exp_rv});
    if (exp_rv) chk({tag, "_pc"}, bus.redirect_pc, exp_pc);
    step();
  endtask

  initial begin
    vectors       = 0;
    errs          = 0;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_start = 32'd0;
    bus.cfg_end   = 32'd0;
    bus.cfg_count = 16'd0;
    bus.pc        = 32'd0;
    bus.pc_valid  = 1'b0;
    bus.abort     = 1'b0;
`ifdef HWLOOP_NEST_EN
    bus.cfg_level = 1'b0;
`endif

    // Reset state
    #2;
    chk("rst_ready",  {31'd0, bus.cfg_ready}, 32'd0);
    chk("rst_redir",  {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_active", {31'd0, bus.loop_active}, 32'd0);
    chk("rst_iter",   {16'd0, bus.iter_remaining}, 32'd0);
    chk("rst_err",    {31'd0, bus.cfg_err}, 32'd0);
    chk("rst_flag",   {31'd0, bus.pc_hwl_end_zero_flag}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.cfg_ready}, 32'd1);
    step();

    // Count-3 loop over 0x100..0x10C: two redirects, then fall through.
    setup(32'h100, 32'h10C, 16'd3, 32'h0FC);
    chk("t1_active", {31'd0, bus.loop_active}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      chk("t1_iter", {16'd0, bus.iter_remaining}, 32'(3 - p));
      for (int w = 0; w < 4; w++)
        fetch(32'h100 + 32'(4 * w), (w == 3) && (p < 2), 32'h100, "t1_redir");
    end
    chk("t1_active_end", {31'd0, bus.loop_active}, 32'd0);
    chk("t1_iter_end", {16'd0, bus.iter_remaining}, 32'd0);
    fetch(32'h110, 1'b0, 32'h0, "t1_exit");

    // Zero-count loop: NOP flag over 0x200..0x208 only.
    setup(32'h200, 32'h208, 16'd0, 32'h1FC);
    chk("t2_active", {31'd0, bus.loop_active}, 32'd1);
    bus.pc = 32'h1F8; bus.pc_valid = 1'b0; #1;
    chk("t2_flag_below", {31'd0, bus.pc_hwl_end_zero_flag}, 32'd0);
    bus.pc = 32'h208; #1;
    chk("t2_flag_stall", {31'd0, bus.pc_hwl_end_zero_flag}, 32'd1);
    step();
    chk("t2_active_stall", {31'd0, bus.loop_active}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      bus.pc = 32'h200 + 32'(4 * w); bus.pc_valid = 1'b1; #1;
      chk("t2_flag_in", {31'd0, bus.pc_hwl_end_zero_flag}, 32'd1);
      chk("t2_no_redir", {31'd0, bus.redirect_valid}, 32'd0);
      step();
    end
    bus.pc = 32'h20C; #1;
    chk("t2_flag_out", {31'd0, bus.pc_hwl_end_zero_flag}, 32'd0);
    chk("t2_active_end", {31'd0, bus.loop_active}, 32'd0);
    step();

    // Rejected setup (end below start).
    chk("t3_err_before", {31'd0, bus.cfg_err}, 32'd0);
    bus.cfg_valid = 1'b1; bus.cfg_start = 32'h104; bus.cfg_end = 32'h100;
    bus.cfg_count = 16'd5; #1;
    chk("t3_ready", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    bus.cfg_valid = 1'b0; #1;
    chk("t3_err", {31'd0, bus.cfg_err}, 32'd1);
    chk("t3_active", {31'd0, bus.loop_active}, 32'd0);
    chk("t3_ready_after", {31'd0, bus.cfg_ready}, 32'd1);

    // Single-word body with unaligned start: equal words are legal.
    setup(32'h303, 32'h300, 16'd2, 32'h2FC);
    fetch(32'h300, 1'b1, 32'h300, "t3_single");
    fetch(32'h300, 1'b0, 32'h0, "t3_single_exit");
    chk("t3_single_idle", {31'd0, bus.loop_active}, 32'd0);
    chk("t3_err_sticky", {31'd0, bus.cfg_err}, 32'd1);

    // Stalled fetch at loop end leaves the count untouched.
    setup(32'h400, 32'h404, 16'd2, 32'h3FC);
    bus.pc = 32'h404; bus.pc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_redir", {31'd0, bus.redirect_valid}, 32'd0);
      step();
    end
    chk("t4_iter_stall", {16'd0, bus.iter_remaining}, 32'd2);
    fetch(32'h404, 1'b1, 32'h400, "t4_redir");
    chk("t4_iter", {16'd0, bus.iter_remaining}, 32'd1);
    fetch(32'h400, 1'b0, 32'h0, "t4_body");
    fetch(32'h404, 1'b0, 32'h0, "t4_exit");
    chk("t4_active_end", {31'd0, bus.loop_active}, 32'd0);

    // Abort at loop end, abort blocking setup, abort masking NOP flag.
    setup(32'h500, 32'h504, 16'd3, 32'h4FC);
    bus.pc = 32'h504; bus.pc_valid = 1'b1; bus.abort = 1'b1; #1;
    chk("t5_abort_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t5_abort_ready", {31'd0, bus.cfg_ready}, 32'd0);
    step();
    bus.abort = 1'b0; #1;
    chk("t5_active", {31'd0, bus.loop_active}, 32'd0);
    chk("t5_iter", {16'd0, bus.iter_remaining}, 32'd0);
    fetch(32'h504, 1'b0, 32'h0, "t5_after");
    bus.abort = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_start = 32'h600;
    bus.cfg_end = 32'h604; bus.cfg_count = 16'd2; bus.pc = 32'h5FC; #1;
    chk("t5_block_ready", {31'd0, bus.cfg_ready}, 32'd0);
    step();
    bus.abort = 1'b0; bus.cfg_valid = 1'b0; #1;
    chk("t5_blocked", {31'd0, bus.loop_active}, 32'd0);
    setup(32'h800, 32'h808, 16'd0, 32'h7FC);
    bus.pc = 32'h804; bus.abort = 1'b1; #1;
    chk("t5_abort_flag", {31'd0, bus.pc_hwl_end_zero_flag}, 32'd0);
    step();
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of a loop.
    setup(32'h700, 32'h704, 16'd3, 32'h6FC);
    bus.pc = 32'h704; bus.pc_valid = 1'b1; #1;
    chk("t6_pre_redir", {31'd0, bus.redirect_valid}, 32'd1);
    #2;
    rst = 1'b1; #1;
    chk("t6_rst_redir",  {31'd0, bus.redirect_valid}, 32'd0);
    chk("t6_rst_active", {31'd0, bus.loop_active}, 32'd0);
    chk("t6_rst_iter",   {16'd0, bus.iter_remaining}, 32'd0);
    chk("t6_rst_ready",  {31'd0, bus.cfg_ready}, 32'd0);
    chk("t6_rst_err",    {31'd0, bus.cfg_err}, 32'd0);
    step();
    rst = 1'b0; #1;
    chk("t6_post_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t6_post_active", {31'd0, bus.loop_active}, 32'd0);
    step();

`ifdef HWLOOP_NEST_EN
    // Outer x2 around inner x3 sharing the end word: six inner passes.
    bus.cfg_level = 1'b0;
    setup(32'h100, 32'h108, 16'd2, 32'h0FC);
    for (int o = 0; o < 2; o++) begin
      bus.cfg_level = 1'b1;
      setup(32'h104, 32'h108, 16'd3, 32'h100);
      bus.cfg_level = 1'b0;
      for (int i = 0; i < 3; i++) begin
        fetch(32'h104, 1'b0, 32'h0, "nest_body");
        fetch(32'h108, (i < 2) || (o == 0), (i < 2) ? 32'h104 : 32'h100, "nest_end");
      end
    end
    chk("nest_idle", {31'd0, bus.loop_active}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
